// File: rtl/game_round_ctl_pkg.sv
// Shared encodings and limits for the shooting-game round controller.
package game_round_ctl_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned MAX_PLAYERS = 4;
    localparam int unsigned WIN_W       = $clog2(MAX_PLAYERS);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_GAME      = 3'd3,
        ST_SCORE     = 3'd4
    } state_t;

endpackage

// File: rtl/game_round_ctl_if.sv
// Round-controller signal bundle: control inputs from mouse/UART, status outputs to drawing.
interface game_round_ctl_if #(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned SEC_W     = 6
);
    import game_round_ctl_pkg::*;

    // Keep the remote-score bus at least one bit wide for single-player builds.
    localparam int unsigned RS_W = (N_PLAYERS > 1) ? (N_PLAYERS - 1) * SCORE_W : 1;

    logic               play_clicked;
    logic               remote_ready;
    logic               stop;
    logic               hit_local;
    logic [RS_W-1:0]    remote_score;

    logic [STATE_W-1:0] state;
    logic [SCORE_W-1:0] local_score;
    logic [SEC_W-1:0]   time_left;
    logic [WIN_W-1:0]   winner;
    logic               tie;
    logic               round_start;
    logic               round_end;

    modport master (
        output play_clicked, remote_ready, stop, hit_local, remote_score,
        input  state, local_score, time_left, winner, tie, round_start, round_end
    );

    modport slave (
        input  play_clicked, remote_ready, stop, hit_local, remote_score,
        output state, local_score, time_left, winner, tie, round_start, round_end
    );

endinterface

// File: rtl/game_round_ctl_sec_timer.sv
// One-second prescaler feeding a loadable seconds down-counter; expire marks the final wrap.
module game_round_ctl_sec_timer #(
    parameter int unsigned CLK_HZ = 75_000_000,
    parameter int unsigned SEC_W  = 6
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [SEC_W-1:0] i_load_val,
    input  logic             i_run,
    output logic [SEC_W-1:0] o_time_left,
    output logic             o_expire
);

    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic [SEC_W-1:0]   r_time_left;
    logic               w_wrap;

    assign w_wrap      = i_run && (r_presc == PRESC_W'(CLK_HZ - 1));
    assign o_expire    = w_wrap && (r_time_left == SEC_W'(1));
    assign o_time_left = r_time_left;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_presc     <= '0;
            r_time_left <= '0;
        end else if (i_load) begin
            r_presc     <= '0;
            r_time_left <= i_load_val;
        end else if (!i_run) begin
            r_presc <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            if (r_time_left != '0) begin
                r_time_left <= r_time_left - SEC_W'(1);
            end
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/game_round_ctl.sv
// Multi-player round sequencer: IDLE/WAIT/COUNTDOWN/GAME/SCORE with local hit counting
// and registered winner/tie evaluation on the SCORE screen.
module game_round_ctl
    import game_round_ctl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 75_000_000,
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned ROUND_SEC = 30,
    parameter int unsigned COUNT_SEC = 3,
    parameter int unsigned SEC_W     = 6
) (
    input logic              pclk,
    input logic              rst,
    game_round_ctl_if.slave  io_bus
);

    state_t             r_state;
    state_t             w_state_d;
    logic [SCORE_W-1:0] r_local_score;
    logic [WIN_W-1:0]   r_winner;
    logic               r_tie;
    logic               r_round_start;
    logic               r_round_end;

    logic [SEC_W-1:0]   w_time_left;
    logic               w_expire;
    logic               w_load;
    logic [SEC_W-1:0]   w_load_val;
    logic               w_run;
    logic               w_entering;

    logic [WIN_W-1:0]   w_winner;
    logic               w_tie;
    logic [SCORE_W-1:0] w_best;
    logic [SCORE_W-1:0] w_cand;

    always_comb begin
        w_state_d = r_state;
        if (io_bus.stop) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.play_clicked) begin
                        w_state_d = (N_PLAYERS == 1) ? ST_COUNTDOWN : ST_WAIT;
                    end
                end
                ST_WAIT:      if (io_bus.remote_ready) w_state_d = ST_COUNTDOWN;
                ST_COUNTDOWN: if (w_expire)            w_state_d = ST_GAME;
                ST_GAME:      if (w_expire)            w_state_d = ST_SCORE;
                ST_SCORE:     if (io_bus.play_clicked) w_state_d = ST_WAIT;
                default:                               w_state_d = ST_IDLE;
            endcase
        end
    end

    // Timer is reloaded on every timed-phase entry and zeroed whenever the round is abandoned.
    assign w_entering = (w_state_d != r_state);
    assign w_run      = (r_state == ST_COUNTDOWN) || (r_state == ST_GAME);

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_entering) begin
            case (w_state_d)
                ST_COUNTDOWN: begin
                    w_load     = 1'b1;
                    w_load_val = SEC_W'(COUNT_SEC);
                end
                ST_GAME: begin
                    w_load     = 1'b1;
                    w_load_val = SEC_W'(ROUND_SEC);
                end
                ST_IDLE: w_load = 1'b1;
                default: w_load = 1'b0;
            endcase
        end
    end

    game_round_ctl_sec_timer #(
        .CLK_HZ (CLK_HZ),
        .SEC_W  (SEC_W)
    ) u_sec_timer (
        .pclk        (pclk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_run       (w_run),
        .o_time_left (w_time_left),
        .o_expire    (w_expire)
    );

    // Strict maximum wins; an equal score only flags a tie against the current leader.
    always_comb begin
        w_best   = r_local_score;
        w_cand   = '0;
        w_winner = '0;
        w_tie    = 1'b0;
        for (int k = 1; k < N_PLAYERS; k++) begin
            w_cand = io_bus.remote_score[(k - 1) * SCORE_W +: SCORE_W];
            if (w_cand > w_best) begin
                w_best   = w_cand;
                w_winner = WIN_W'(k);
                w_tie    = 1'b0;
            end else if (w_cand == w_best) begin
                w_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_local_score <= '0;
            r_winner      <= '0;
            r_tie         <= 1'b0;
            r_round_start <= 1'b0;
            r_round_end   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_round_start <= (w_state_d == ST_GAME) && (r_state != ST_GAME);
            r_round_end   <= (w_state_d == ST_SCORE) && (r_state != ST_SCORE);

            // The SCORE screen keeps the finished round's count even when aborted.
            if (io_bus.stop && (r_state != ST_SCORE)) begin
                r_local_score <= '0;
            end else if ((w_state_d == ST_COUNTDOWN) && (r_state != ST_COUNTDOWN)) begin
                r_local_score <= '0;
            end else if ((r_state == ST_GAME) && io_bus.hit_local && (r_local_score != '1)) begin
                r_local_score <= r_local_score + SCORE_W'(1);
            end

            if (r_state == ST_SCORE) begin
                r_winner <= w_winner;
                r_tie    <= w_tie;
            end
        end
    end

    assign io_bus.state       = r_state;
    assign io_bus.local_score = r_local_score;
    assign io_bus.time_left   = w_time_left;
    assign io_bus.winner      = r_winner;
    assign io_bus.tie         = r_tie;
    assign io_bus.round_start = r_round_start;
    assign io_bus.round_end   = r_round_end;

endmodule

// File: tb/tb_game_round_ctl.sv
// Scoreboard bench for game_round_ctl: a 3-player instance and a 1-player 3-bit-score instance.
module tb_game_round_ctl;
    import game_round_ctl_pkg::*;

    localparam int unsigned HZ = 10;
    localparam int unsigned CS = 3;
    localparam int unsigned RS = 5;

    typedef struct {
        string tag;
        int    which;
        int    st, ls, tl, w, t, rs, re;
    } exp_t;

    logic pclk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n_start = 0;
    int   n_end   = 0;
    exp_t sb_q[$];

    always #5 pclk = ~pclk;

    game_round_ctl_if #(.N_PLAYERS(3), .SCORE_W(8), .SEC_W(6)) bus ();
    game_round_ctl_if #(.N_PLAYERS(1), .SCORE_W(3), .SEC_W(6)) bus1 ();

    game_round_ctl #(
        .CLK_HZ(HZ), .N_PLAYERS(3), .SCORE_W(8), .ROUND_SEC(RS), .COUNT_SEC(CS), .SEC_W(6)
    ) dut (
        .pclk   (pclk),
        .rst    (rst),
        .io_bus (bus)
    );

    game_round_ctl #(
        .CLK_HZ(HZ), .N_PLAYERS(1), .SCORE_W(3), .ROUND_SEC(RS), .COUNT_SEC(CS), .SEC_W(6)
    ) dut1 (
        .pclk   (pclk),
        .rst    (rst),
        .io_bus (bus1)
    );

    always @(negedge pclk) begin
        if (bus.round_start) n_start++;
        if (bus.round_end)   n_end++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic int cur_state(input int which);
        return (which == 0) ? int'(bus.state) : int'(bus1.state);
    endfunction

    // Fields set to -1 are not compared.
    task automatic expect_out(input string tag, input int which, input int st, input int ls,
                              input int tl, input int w, input int t, input int rs, input int re);
        exp_t e;
        e.tag = tag; e.which = which;
        e.st = st; e.ls = ls; e.tl = tl; e.w = w; e.t = t; e.rs = rs; e.re = re;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        int o_st, o_ls, o_tl, o_w, o_t, o_rs, o_re;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        if (e.which == 0) begin
            o_st = int'(bus.state);       o_ls = int'(bus.local_score);
            o_tl = int'(bus.time_left);   o_w  = int'(bus.winner);
            o_t  = int'(bus.tie);         o_rs = int'(bus.round_start);
            o_re = int'(bus.round_end);
        end else begin
            o_st = int'(bus1.state);      o_ls = int'(bus1.local_score);
            o_tl = int'(bus1.time_left);  o_w  = int'(bus1.winner);
            o_t  = int'(bus1.tie);        o_rs = int'(bus1.round_start);
            o_re = int'(bus1.round_end);
        end
        if (e.st >= 0) chk({e.tag, ".state"},       o_st, e.st);
        if (e.ls >= 0) chk({e.tag, ".local_score"}, o_ls, e.ls);
        if (e.tl >= 0) chk({e.tag, ".time_left"},   o_tl, e.tl);
        if (e.w  >= 0) chk({e.tag, ".winner"},      o_w,  e.w);
        if (e.t  >= 0) chk({e.tag, ".tie"},         o_t,  e.t);
        if (e.rs >= 0) chk({e.tag, ".round_start"}, o_rs, e.rs);
        if (e.re >= 0) chk({e.tag, ".round_end"},   o_re, e.re);
    endtask

    task automatic run_until(input int which, input int st, input int budget, input string tag);
        int n = 0;
        while (cur_state(which) != st && n < budget) begin
            tick();
            n++;
        end
        chk({tag, ".reached"}, cur_state(which), st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst = 1'b1;
        bus.play_clicked = 0;  bus.remote_ready = 0; bus.stop = 0; bus.hit_local = 0;
        bus.remote_score = '0;
        bus1.play_clicked = 0; bus1.remote_ready = 0; bus1.stop = 0; bus1.hit_local = 0;
        bus1.remote_score = '0;
        repeat (3) tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        compare_out();
        compare_out();
        rst = 1'b0;

        // Basic round with remote players already ready.
        bus.remote_ready = 1;
        bus.remote_score = {8'd4, 8'd9};
        bus.play_clicked = 1;
        expect_out("wait", 0, 1, 0, 0, -1, -1, 0, 0);
        tick();
        bus.play_clicked = 0;
        compare_out();
        expect_out("cd_entry", 0, 2, 0, 3, -1, -1, 0, 0);
        tick();
        compare_out();

        i = 0;
        while (bus.state == 3'd2 && i < 100) begin
            if (i % 10 == 0 || i % 10 == 9) begin
                expect_out("cd_time", 0, 2, 0, 3 - i / 10, -1, -1, -1, 0);
                compare_out();
            end
            bus.hit_local = (i == 5 || i == 12);
            tick();
            bus.hit_local = 0;
            i++;
        end
        chk("cd_cycles", i, 30);
        expect_out("game_entry", 0, 3, 0, 5, -1, -1, 1, 0);
        compare_out();

        i = 0;
        while (bus.state == 3'd3 && i < 200) begin
            if (i == 1) begin
                expect_out("hit_latency", 0, 3, 1, 5, -1, -1, 0, 0);
                compare_out();
            end
            bus.hit_local = (i == 0 || i == 10 || i == 20 || i == 30 || i == 40 ||
                             i == 45 || i == 49);
            tick();
            bus.hit_local = 0;
            i++;
        end
        chk("game_cycles", i, 50);
        expect_out("score_entry", 0, 4, 7, 0, 0, 0, 0, 1);
        compare_out();

        // Winner/tie: local=7 against remote players 1 and 2.
        tick();
        expect_out("win_p1", 0, 4, 7, 0, 1, 0, 0, 0);
        compare_out();
        bus.remote_score = {8'd7, 8'd7};
        tick();
        expect_out("tie_all", 0, 4, 7, 0, 0, 1, 0, 0);
        compare_out();
        bus.remote_score = {8'd8, 8'd4};
        tick();
        expect_out("win_p2", 0, 4, 7, 0, 2, 0, 0, 0);
        compare_out();
        bus.remote_score = {8'd8, 8'd8};
        tick();
        expect_out("tie_p1p2", 0, 4, 7, 0, 1, 1, 0, 0);
        compare_out();
        chk("n_start_basic", n_start, 1);
        chk("n_end_basic", n_end, 1);

        // Rematch keeps score and winner until the next countdown.
        bus.remote_ready = 0;
        bus.play_clicked = 1;
        tick();
        bus.play_clicked = 0;
        expect_out("rematch", 0, 1, 7, 0, 1, 1, 0, 0);
        compare_out();
        repeat (4) tick();
        expect_out("wait_hold", 0, 1, 7, 0, -1, -1, 0, 0);
        compare_out();
        bus.remote_ready = 1;
        tick();
        expect_out("cd_clear", 0, 2, 0, 3, 1, 1, 0, 0);
        compare_out();

        // Abort mid-GAME with a simultaneous hit.
        run_until(0, 3, 100, "abort_game");
        bus.hit_local = 1;
        tick();
        bus.hit_local = 0;
        repeat (5) tick();
        expect_out("abort_pre", 0, 3, 1, -1, -1, -1, 0, 0);
        compare_out();
        bus.stop = 1;
        bus.hit_local = 1;
        tick();
        bus.stop = 0;
        bus.hit_local = 0;
        expect_out("abort", 0, 0, 0, 0, -1, -1, 0, 0);
        compare_out();
        repeat (3) tick();
        chk("abort_no_end", n_end, 1);

        // Hit on the expiry cycle is counted; stop in SCORE keeps the score.
        bus.play_clicked = 1;
        tick();
        bus.play_clicked = 0;
        run_until(0, 3, 100, "exp_game");
        repeat (49) tick();
        bus.hit_local = 1;
        tick();
        bus.hit_local = 0;
        expect_out("last_hit", 0, 4, 1, 0, -1, -1, 0, 1);
        compare_out();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        expect_out("stop_score", 0, 0, 1, 0, -1, -1, 0, 0);
        compare_out();

        // Stop coinciding with expiry.
        bus.play_clicked = 1;
        tick();
        bus.play_clicked = 0;
        run_until(0, 3, 100, "stopexp_game");
        repeat (49) tick();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        expect_out("stop_expiry", 0, 0, 0, 0, -1, -1, 0, 0);
        compare_out();
        repeat (2) tick();
        chk("stopexp_no_end", n_end, 2);

        // Reset during COUNTDOWN.
        bus.play_clicked = 1;
        tick();
        bus.play_clicked = 0;
        run_until(0, 2, 10, "rst_cd");
        repeat (7) tick();
        rst = 1;
        tick();
        rst = 0;
        expect_out("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        compare_out();

        // Single player: direct to COUNTDOWN, 3-bit score saturates.
        bus1.play_clicked = 1;
        tick();
        bus1.play_clicked = 0;
        expect_out("solo_cd", 1, 2, 0, 3, -1, -1, 0, 0);
        compare_out();
        run_until(1, 3, 100, "solo_game");
        expect_out("solo_game", 1, 3, 0, 5, -1, -1, 1, 0);
        compare_out();
        bus1.hit_local = 1;
        repeat (9) tick();
        bus1.hit_local = 0;
        expect_out("solo_sat", 1, 3, 7, -1, -1, -1, 0, 0);
        compare_out();

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
